// File: rtl/fir_out_fifo.sv
// Elastic AXI-Stream output buffer behind the FIR master port: absorbs unthrottled
// single-cycle result pulses, re-presents them with valid/ready, tracks frames and overrun.
module fir_out_fifo #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH      = 16,
  parameter int unsigned pPTR_W      = 4,
  parameter int unsigned pAF_MARGIN  = 2
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   clr,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [pPTR_W:0]        level,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [31:0]            frame_beats,
  output logic                   frame_done
);

  localparam int unsigned     ENTRY_W  = pDATA_WIDTH + 1;
  localparam int unsigned     LVL_W    = pPTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(pDEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(pDEPTH - pAF_MARGIN);

  logic [ENTRY_W-1:0] r_mem [pDEPTH];
  logic [pPTR_W-1:0]  r_wr_ptr;
  logic [pPTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;
  logic [31:0]        r_frame_beats;
  logic               r_frame_done;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_pop_last;
  logic [ENTRY_W-1:0] w_head;

  // Status decodes come from registered occupancy only; clr masks all traffic.
  assign w_full     = (r_level == FULL_LVL);
  assign w_empty    = (r_level == '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_push     = s_tvalid & ~w_full & ~clr;
  assign w_drop     = s_tvalid &  w_full & ~clr;
  assign w_pop      = ~w_empty & m_tready & ~clr;
  assign w_pop_last = w_pop & w_head[pDATA_WIDTH];

  // First-word fall-through view of the head entry, zeroed when empty.
  assign s_tready    = ~w_full;
  assign m_tvalid    = ~w_empty;
  assign m_tdata     = w_empty ? '0 : w_head[pDATA_WIDTH-1:0];
  assign m_tlast     = ~w_empty & w_head[pDATA_WIDTH];
  assign level       = r_level;
  assign almost_full = (r_level >= AF_LVL);
  assign overflow    = r_overflow;
  assign frame_beats = r_frame_beats;
  assign frame_done  = r_frame_done;

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge axis_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + pPTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + pPTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overrun flag and per-frame beat accounting on the pop side.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_overflow    <= 1'b0;
      r_frame_beats <= '0;
      r_frame_done  <= 1'b0;
    end else if (clr) begin
      r_overflow    <= 1'b0;
      r_frame_beats <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_last) begin
        r_frame_beats <= '0;
      end else if (w_pop) begin
        r_frame_beats <= r_frame_beats + 32'd1;
      end
      r_frame_done <= w_pop_last;
    end
  end

endmodule
